// File: rtl/path_bist_pkg.sv
// Shared types and default constants for the single-path BIST controller.
// The LFSR/MISR defaults describe a 16-bit maximal-length Fibonacci polynomial.
package path_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } bist_state_e;

    localparam logic [15:0] DEF_SEED = 16'hACE1;
    localparam logic [15:0] DEF_TAPS = 16'hB400;

endpackage

// File: rtl/bist_lfsr.sv
// Fibonacci shift register with parallel-XOR input: a pattern generator when
// xor_in is zero, a multiple-input signature register otherwise.
module bist_lfsr
    import path_bist_pkg::*;
#(
    parameter int                WIDTH = 16,
    parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(DEF_TAPS)
) (
    input  logic             clk,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  logic [WIDTH-1:0] xor_in,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_r;

    function automatic logic [WIDTH-1:0] shift_fb(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] r;
        r    = s << 1;
        r[0] = ^(s & TAPS);
        return r;
    endfunction

    // Load (also used as the reset path by the parent) wins over stepping.
    always_ff @(posedge clk) begin
        if (load) begin
            state_r <= load_val;
        end else if (enable) begin
            state_r <= shift_fb(state_r) ^ xor_in;
        end else begin
            state_r <= state_r;
        end
    end

    assign state = state_r;

endmodule

// File: rtl/path_bist_ctrl.sv
// Built-in self-test controller: drives LFSR patterns through CHANNELS
// single-bit paths (with optional stuck-at injection) and compacts the
// registered responses into a MISR compared against a golden signature.
module path_bist_ctrl
    import path_bist_pkg::*;
#(
    parameter int                   CHANNELS = 4,
    parameter int                   LFSR_W   = 16,
    parameter int                   PATTERNS = 256,
    parameter logic [CHANNELS-1:0]  POL_MASK = {CHANNELS{1'b0}},
    parameter logic [LFSR_W-1:0]    SEED     = LFSR_W'(DEF_SEED),
    parameter logic [LFSR_W-1:0]    TAPS     = LFSR_W'(DEF_TAPS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [CHANNELS-1:0]              fault_en,
    input  logic [CHANNELS-1:0]              fault_val,
    input  logic [LFSR_W-1:0]                golden_sig,
    output logic                             busy,
    output logic                             done,
    output logic                             pass,
    output logic [LFSR_W-1:0]                signature,
    output logic [$clog2(PATTERNS+1)-1:0]    pattern_cnt
);

    localparam int               CNT_W    = $clog2(PATTERNS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PATTERNS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PATTERNS);

    if (CHANNELS < 1 || CHANNELS > LFSR_W) begin : g_bad_channels
        $error("path_bist_ctrl: CHANNELS must be in 1..LFSR_W");
    end
    if (PATTERNS < 1) begin : g_bad_patterns
        $error("path_bist_ctrl: PATTERNS must be at least 1");
    end
    if (SEED == {LFSR_W{1'b0}}) begin : g_bad_seed
        $error("path_bist_ctrl: SEED must be non-zero");
    end

    bist_state_e          state_r, state_s;
    logic                 busy_r, done_r, pass_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [CHANNELS-1:0]  fen_r, fval_r, path_r, path_s;
    logic                 path_vld_r;
    logic                 lfsr_load_s, lfsr_en_s, misr_load_s;
    logic [LFSR_W-1:0]    lfsr_s, misr_s, misr_xor_s;
    logic                 unused_lfsr_s;

    // Next-state decode and datapath control.
    always_comb begin
        state_s     = state_r;
        lfsr_load_s = 1'b0;
        lfsr_en_s   = 1'b0;
        misr_load_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_SEED;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEED: begin
                state_s     = ST_RUN;
                lfsr_load_s = 1'b1;
                misr_load_s = 1'b1;
            end
            ST_RUN: begin
                lfsr_en_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FLUSH: state_s = ST_DONE;
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
        if (rst) begin
            lfsr_load_s = 1'b1;
            misr_load_s = 1'b1;
        end else begin
            lfsr_load_s = lfsr_load_s;
            misr_load_s = misr_load_s;
        end
    end

    // Faulted channels ignore the stimulus entirely; healthy ones apply polarity.
    assign path_s        = ((lfsr_s[CHANNELS-1:0] ^ POL_MASK) & ~fen_r) | (fval_r & fen_r);
    assign misr_xor_s    = LFSR_W'(path_r);
    assign unused_lfsr_s = ^lfsr_s;

    // FSM state, registered status outputs, fault latches and path register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            fen_r      <= {CHANNELS{1'b0}};
            fval_r     <= {CHANNELS{1'b0}};
            path_r     <= {CHANNELS{1'b0}};
            path_vld_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            busy_r     <= (state_s == ST_SEED) || (state_s == ST_RUN) || (state_s == ST_FLUSH);
            done_r     <= (state_s == ST_DONE);
            path_r     <= path_s;
            path_vld_r <= (state_r == ST_RUN);
            if (state_r == ST_SEED) begin
                cnt_r  <= {CNT_W{1'b0}};
                fen_r  <= fault_en;
                fval_r <= fault_val;
            end else if ((state_r == ST_RUN) && (cnt_r != CNT_MAX)) begin
                cnt_r  <= cnt_r + CNT_W'(1);
                fen_r  <= fen_r;
                fval_r <= fval_r;
            end else begin
                cnt_r  <= cnt_r;
                fen_r  <= fen_r;
                fval_r <= fval_r;
            end
        end
    end

    // Verdict is taken once the last response has been compacted, then held.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_r <= 1'b0;
        end else if (state_r == ST_SEED) begin
            pass_r <= 1'b0;
        end else if (state_r == ST_DONE) begin
            pass_r <= (misr_s == golden_sig);
        end else begin
            pass_r <= pass_r;
        end
    end

    bist_lfsr #(
        .WIDTH (LFSR_W),
        .TAPS  (TAPS)
    ) u_pattern_lfsr (
        .clk      (clk),
        .load     (lfsr_load_s),
        .load_val (SEED),
        .enable   (lfsr_en_s),
        .xor_in   ({LFSR_W{1'b0}}),
        .state    (lfsr_s)
    );

    bist_lfsr #(
        .WIDTH (LFSR_W),
        .TAPS  (TAPS)
    ) u_misr (
        .clk      (clk),
        .load     (misr_load_s),
        .load_val ({LFSR_W{1'b0}}),
        .enable   (path_vld_r),
        .xor_in   (misr_xor_s),
        .state    (misr_s)
    );

    assign busy        = busy_r;
    assign done        = done_r;
    assign pass        = pass_r;
    assign signature   = misr_s;
    assign pattern_cnt = cnt_r;

endmodule

// File: tb/tb_path_bist_ctrl.sv
// Self-checking bench: three controller configurations driven together and
// compared against a pattern-by-pattern reference model of the signature.
module tb_path_bist_ctrl;

    localparam int          P    = 256;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] TAPS = 16'hB400;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [3:0]  fault_en, fault_val;
    logic [15:0] golden_def, golden_pol, golden_one;

    logic        busy_def, done_def, pass_def;
    logic [15:0] sig_def;
    logic [8:0]  cnt_def;
    logic        busy_pol, done_pol, pass_pol;
    logic [15:0] sig_pol;
    logic [8:0]  cnt_pol;
    logic        busy_one, done_one, pass_one;
    logic [15:0] sig_one;
    logic [0:0]  cnt_one;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    path_bist_ctrl dut_def (
        .clk(clk), .rst(rst), .start(start), .fault_en(fault_en), .fault_val(fault_val),
        .golden_sig(golden_def), .busy(busy_def), .done(done_def), .pass(pass_def),
        .signature(sig_def), .pattern_cnt(cnt_def)
    );

    path_bist_ctrl #(.POL_MASK(4'b1111)) dut_pol (
        .clk(clk), .rst(rst), .start(start), .fault_en(fault_en), .fault_val(fault_val),
        .golden_sig(golden_pol), .busy(busy_pol), .done(done_pol), .pass(pass_pol),
        .signature(sig_pol), .pattern_cnt(cnt_pol)
    );

    path_bist_ctrl #(.CHANNELS(1), .PATTERNS(1), .POL_MASK(1'b0)) dut_one (
        .clk(clk), .rst(rst), .start(start), .fault_en(fault_en[0:0]), .fault_val(fault_val[0:0]),
        .golden_sig(golden_one), .busy(busy_one), .done(done_one), .pass(pass_one),
        .signature(sig_one), .pattern_cnt(cnt_one)
    );

    function automatic logic [15:0] step(input logic [15:0] s);
        return (s << 1) | {15'd0, ^(s & TAPS)};
    endfunction

    // Signature after compacting pats responses, straight from the path rules.
    function automatic logic [15:0] model_sig(input int pats, input int ch, input logic [15:0] pol,
                                              input logic [3:0] en, input logic [3:0] val);
        logic [15:0] lfsr, misr, resp;
        lfsr = SEED;
        misr = 16'd0;
        for (int k = 0; k < pats; k++) begin
            resp = 16'd0;
            for (int i = 0; i < ch; i++) begin
                resp[i] = en[i] ? val[i] : (lfsr[i] ^ pol[i]);
            end
            misr = step(misr) ^ resp;
            lfsr = step(lfsr);
        end
        return misr;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One run from an IDLE cycle; optional mid-run input scrambling and stray start.
    task automatic run_one(input string tag, input logic [3:0] en, input logic [3:0] val,
                           input bit scramble,
                           output logic [15:0] sd, output logic [15:0] sp, output logic [15:0] so,
                           output logic pd, output logic pp, output logic po);
        int busy_bad, done_bad, cnt_bad, one_bad;
        bit exp_busy;
        busy_bad = 0; done_bad = 0; cnt_bad = 0; one_bad = 0;
        sd = 16'd0; sp = 16'd0; so = 16'd0; po = 1'b0;
        fault_en  = en;
        fault_val = val;
        start     = 1'b1;
        for (int c = 1; c <= P + 3; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (scramble && c == 40) begin
                fault_en  = ~en;
                fault_val = 4'($urandom);
                start     = 1'b1;
            end
            if (scramble && c == 41) start = 1'b0;
            exp_busy = (c <= P + 2);
            if (busy_def !== exp_busy) busy_bad++;
            if (done_def !== (c == P + 3)) done_bad++;
            if (c >= 2 && c <= P + 2 && cnt_def !== 9'(c - 2)) cnt_bad++;
            if (c <= 10) begin
                if (busy_one !== (c <= 3)) one_bad++;
                if (done_one !== (c == 4)) one_bad++;
            end
            if (c == 4) begin
                so = sig_one;
                chk({tag, " one_cnt"}, 32'(cnt_one), 32'd1);
            end
            if (c == 5) po = pass_one;
            if (c == P + 3) begin
                sd = sig_def;
                sp = sig_pol;
                chk({tag, " cnt_at_done"}, 32'(cnt_def), 32'd256);
            end
        end
        chk({tag, " busy_window"}, 32'(busy_bad), 32'd0);
        chk({tag, " done_pulse"},  32'(done_bad), 32'd0);
        chk({tag, " cnt_ramp"},    32'(cnt_bad),  32'd0);
        chk({tag, " one_timing"},  32'(one_bad),  32'd0);
        tick();
        pd = pass_def;
        pp = pass_pol;
        chk({tag, " idle_after"}, {30'd0, busy_def, done_def}, 32'd0);
        tick();
        chk({tag, " no_queued_start"}, 32'(busy_def), 32'd0);
        chk({tag, " cnt_saturated"},   32'(cnt_def),  32'd256);
        fault_en  = 4'd0;
        fault_val = 4'd0;
    endtask

    typedef struct {
        logic [3:0] en;
        logic [3:0] val;
        bit         scramble;
        bit         exp_pass_def;
        bit         exp_pass_pol;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [15:0] sd, sp, so, ref_sig, first_sd;
        logic        pd, pp, po;
        logic [3:0]  en, val;
        bit          scr;
        int          ndone, overlap, first_done, second_done;
        logic [15:0] hsig[2];

        vecs[0] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{4'b1000, 4'b1111, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{4'b1111, 4'b0101, 1'b1, 1'b0, 1'b0};

        golden_def = model_sig(P, 4, 16'h0000, 4'd0, 4'd0);
        golden_pol = model_sig(P, 4, 16'h000F, 4'd0, 4'd0);
        golden_one = model_sig(1, 1, 16'h0000, 4'd0, 4'd0);
        first_sd   = 16'd0;

        rst = 1'b1; start = 1'b0; fault_en = 4'd0; fault_val = 4'd0;
        tick(); tick(); tick();
        chk("reset_def", {12'd0, cnt_def, busy_def, done_def, pass_def} | {16'd0, sig_def}, 32'd0);
        chk("reset_pol", {12'd0, cnt_pol, busy_pol, done_pol, pass_pol} | {16'd0, sig_pol}, 32'd0);
        chk("reset_one", {28'd0, cnt_one, busy_one, done_one, pass_one} | {16'd0, sig_one}, 32'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 5; v++) begin
            run_one($sformatf("vec%0d", v), vecs[v].en, vecs[v].val, vecs[v].scramble,
                    sd, sp, so, pd, pp, po);
            chk($sformatf("vec%0d sig_def", v), 32'(sd), 32'(model_sig(P, 4, 16'h0000, vecs[v].en, vecs[v].val)));
            chk($sformatf("vec%0d sig_pol", v), 32'(sp), 32'(model_sig(P, 4, 16'h000F, vecs[v].en, vecs[v].val)));
            chk($sformatf("vec%0d pass_def", v), 32'(pd), 32'(vecs[v].exp_pass_def));
            chk($sformatf("vec%0d pass_pol", v), 32'(pp), 32'(vecs[v].exp_pass_pol));
            chk($sformatf("vec%0d sig_differs", v), 32'(sd != golden_def), 32'(!vecs[v].exp_pass_def));
            chk($sformatf("vec%0d sig_one", v), 32'(so), 32'(model_sig(1, 1, 16'h0000, vecs[v].en, vecs[v].val)));
            chk($sformatf("vec%0d pass_one", v), 32'(po), 32'(so == golden_one));
            if (v == 0) first_sd = sd;
        end
        chk("one_seed_bit", 32'(golden_one), {31'd0, SEED[0]});
        chk("defaults_sig", 32'(first_sd), 32'(golden_def));

        for (int r = 0; r < 4; r++) begin
            en  = 4'($urandom_range(0, 15));
            val = 4'($urandom);
            scr = 1'($urandom_range(0, 1));
            run_one($sformatf("rnd%0d", r), en, val, scr, sd, sp, so, pd, pp, po);
            ref_sig = model_sig(P, 4, 16'h0000, en, val);
            chk($sformatf("rnd%0d sig_def", r), 32'(sd), 32'(ref_sig));
            chk($sformatf("rnd%0d pass_def", r), 32'(pd), 32'(ref_sig == golden_def));
            chk($sformatf("rnd%0d sig_pol", r), 32'(sp), 32'(model_sig(P, 4, 16'h000F, en, val)));
        end

        // Reset in the middle of a run.
        start = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (c == 1) start = 1'b0;
        end
        rst = 1'b1;
        tick();
        chk("abort_outputs", {12'd0, cnt_def, busy_def, done_def, pass_def} | {16'd0, sig_def}, 32'd0);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (done_def) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        run_one("after_abort", 4'd0, 4'd0, 1'b0, sd, sp, so, pd, pp, po);
        chk("after_abort sig", 32'(sd), 32'(golden_def));
        chk("after_abort pass", 32'(pd), 32'd1);

        // start held high: back-to-back runs, each starting with an IDLE cycle.
        ndone = 0; overlap = 0; first_done = 0; second_done = 0;
        hsig[0] = 16'd0; hsig[1] = 16'd0;
        start = 1'b1;
        for (int c = 1; c <= 600; c++) begin
            tick();
            if (busy_def && done_def) overlap++;
            if (done_def) begin
                if (ndone < 2) hsig[ndone] = sig_def;
                if (ndone == 0) first_done = c;
                if (ndone == 1) second_done = c;
                ndone++;
            end else if (c > 1 && (c == first_done + 1 || c == second_done + 1) && busy_def) begin
                overlap++;
            end
        end
        start = 1'b0;
        chk("hold_runs", 32'(ndone), 32'd2);
        chk("hold_first_done", 32'(first_done), 32'd259);
        chk("hold_second_done", 32'(second_done), 32'd519);
        chk("hold_overlap", 32'(overlap), 32'd0);
        chk("hold_sig_equal", 32'(hsig[1]), 32'(hsig[0]));
        chk("hold_sig_ref", 32'(hsig[0]), 32'(golden_def));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
